// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard interface: hazard inputs from the datapath and the
// per-stage control codes / status returned by hazard_ctrl.
interface hazard_ctrl_if;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        ID_Jump;
    logic        EX_BranchTaken;
    logic        Mem_req;
    logic        Mem_ready;
    logic        PC_Write;
    logic [1:0]  IFID_Ctrl;
    logic [1:0]  IDEX_Ctrl;
    logic [1:0]  EXMEM_Ctrl;
    logic [1:0]  MEMWB_Ctrl;
    logic        Mem_timeout;
    logic [31:0] Stall_cnt;
    logic [31:0] Flush_cnt;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
               ID_Jump, EX_BranchTaken, Mem_req, Mem_ready,
        input  PC_Write, IFID_Ctrl, IDEX_Ctrl, EXMEM_Ctrl, MEMWB_Ctrl,
               Mem_timeout, Stall_cnt, Flush_cnt
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
               ID_Jump, EX_BranchTaken, Mem_req, Mem_ready,
        output PC_Write, IFID_Ctrl, IDEX_Ctrl, EXMEM_Ctrl, MEMWB_Ctrl,
               Mem_timeout, Stall_cnt, Flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: stall/flush codes, PC write enable,
// memory-wait FSM with timeout. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hif
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [1:0]        CTRL_ADV   = 2'b00;
    localparam logic [1:0]        CTRL_HOLD  = 2'b01;
    localparam logic [1:0]        CTRL_FLUSH = 2'b10;
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_q;
    logic              mem_stall, load_use;
    logic              branch_fire, lu_fire, jump_fire;

    // Priority: memory stall > branch > load-use > jump.
    always_comb begin
        mem_stall   = hif.Mem_req & ~hif.Mem_ready;
        load_use    = hif.IDEX_MemRead && (hif.IDEX_Rt != 5'd0) &&
                      ((hif.IDEX_Rt == hif.IFID_Rs) ||
                       (hif.IFID_UsesRt && (hif.IDEX_Rt == hif.IFID_Rt)));
        branch_fire = ~mem_stall & hif.EX_BranchTaken;
        lu_fire     = ~mem_stall & ~hif.EX_BranchTaken & load_use;
        jump_fire   = ~mem_stall & ~hif.EX_BranchTaken & ~load_use & hif.ID_Jump;
    end

    always_comb begin
        hif.PC_Write   = 1'b1;
        hif.IFID_Ctrl  = CTRL_ADV;
        hif.IDEX_Ctrl  = CTRL_ADV;
        hif.EXMEM_Ctrl = CTRL_ADV;
        hif.MEMWB_Ctrl = CTRL_ADV;
        if (!reset) begin
            hif.PC_Write   = 1'b0;
            hif.IFID_Ctrl  = CTRL_FLUSH;
            hif.IDEX_Ctrl  = CTRL_FLUSH;
            hif.EXMEM_Ctrl = CTRL_FLUSH;
            hif.MEMWB_Ctrl = CTRL_FLUSH;
        end else if (mem_stall) begin
            hif.PC_Write   = 1'b0;
            hif.IFID_Ctrl  = CTRL_HOLD;
            hif.IDEX_Ctrl  = CTRL_HOLD;
            hif.EXMEM_Ctrl = CTRL_HOLD;
            hif.MEMWB_Ctrl = CTRL_FLUSH;
        end else if (branch_fire) begin
            hif.IFID_Ctrl  = CTRL_FLUSH;
            hif.IDEX_Ctrl  = CTRL_FLUSH;
        end else if (lu_fire) begin
            hif.PC_Write   = 1'b0;
            hif.IFID_Ctrl  = CTRL_HOLD;
            hif.IDEX_Ctrl  = CTRL_FLUSH;
        end else if (jump_fire) begin
            hif.IFID_Ctrl  = CTRL_FLUSH;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN:      if (mem_stall) state_nxt = MEM_WAIT;
            MEM_WAIT: if (hif.Mem_ready || !hif.Mem_req) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Counter only clears on a ready cycle; it holds across idle cycles.
    always_comb begin
        wait_nxt = wait_cnt;
        if (hif.Mem_ready)
            wait_nxt = '0;
        else if (mem_stall && (wait_cnt != WAIT_MAX))
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX)
                timeout_q <= 1'b1;
        end
    end

    assign hif.Mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_fire)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (branch_fire || jump_fire)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hif.Stall_cnt = stall_cnt_q;
    assign hif.Flush_cnt = flush_cnt_q;
`else
    assign hif.Stall_cnt = '0;
    assign hif.Flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a behavioural hazard model.
module tb_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .WAIT_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (hif.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          m_wait = 0;
    bit          m_timeout = 0;
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;

    // Event class seen this cycle: 0 reset, 1 memory stall, 2 branch, 3 load-use, 4 jump, 5 none
    function automatic int event_class();
        bit lu;
        lu = hif.IDEX_MemRead && hif.IDEX_Rt != 0 &&
             (hif.IDEX_Rt == hif.IFID_Rs || (hif.IFID_UsesRt && hif.IDEX_Rt == hif.IFID_Rt));
        if (!reset) return 0;
        if (hif.Mem_req && !hif.Mem_ready) return 1;
        if (hif.EX_BranchTaken) return 2;
        if (lu) return 3;
        if (hif.ID_Jump) return 4;
        return 5;
    endfunction

    // {PC_Write, IFID, IDEX, EXMEM, MEMWB}
    function automatic logic [8:0] exp_vec();
        case (event_class())
            0:       return 9'b0_10_10_10_10;
            1:       return 9'b0_01_01_01_10;
            2:       return 9'b1_10_10_00_00;
            3:       return 9'b0_01_10_00_00;
            4:       return 9'b1_10_00_00_00;
            default: return 9'b1_00_00_00_00;
        endcase
    endfunction

    function automatic logic [8:0] dut_vec();
        return {hif.PC_Write, hif.IFID_Ctrl, hif.IDEX_Ctrl, hif.EXMEM_Ctrl, hif.MEMWB_Ctrl};
    endfunction

    function automatic logic [31:0] exp_stall_cnt();
`ifdef HAZARD_PERF_EN
        return m_stall_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush_cnt();
`ifdef HAZARD_PERF_EN
        return m_flush_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_clear();
        m_wait = 0;
        m_timeout = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge();
        int ec;
        ec = event_class();
        if (ec == 0) begin
            model_clear();
        end else begin
            if (hif.Mem_ready) m_wait = 0;
            else if (ec == 1 && m_wait < TO) m_wait = m_wait + 1;
            if (m_wait == TO) m_timeout = 1;
            if (ec == 3) m_stall_cnt = m_stall_cnt + 1;
            if (ec == 2 || ec == 4) m_flush_cnt = m_flush_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply(input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] irt, input bit uses, input bit jmp,
                         input bit br, input bit req, input bit rdy);
        hif.IDEX_MemRead   = mr;
        hif.IDEX_Rt        = rt;
        hif.IFID_Rs        = rs;
        hif.IFID_Rt        = irt;
        hif.IFID_UsesRt    = uses;
        hif.ID_Jump        = jmp;
        hif.EX_BranchTaken = br;
        hif.Mem_req        = req;
        hif.Mem_ready      = rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        checks++;
        if (dut_vec() !== 9'b0_10_10_10_10) begin
            errors++; $display("FAIL reset_ctrl got %b want %b", dut_vec(), 9'b0_10_10_10_10);
        end
        tick();
        checks++;
        if (hif.Mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got %b want 0", hif.Mem_timeout);
        end
        checks++;
        if (hif.Stall_cnt !== 32'd0 || hif.Flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hif.Stall_cnt, hif.Flush_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL idle_ctrl got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
    endtask

    task automatic test_load_use();
        apply(1, 5, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b0_01_10_00_00) begin
            errors++; $display("FAIL lu_rs got %b want %b", dut_vec(), 9'b0_01_10_00_00);
        end
        tick();
        apply(0, 5, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL lu_release got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
        apply(1, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL lu_r0 got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
    endtask

    task automatic test_uses_rt();
        apply(1, 7, 3, 7, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL rt_unused got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
        apply(1, 7, 3, 7, 1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b0_01_10_00_00) begin
            errors++; $display("FAIL rt_used got %b want %b", dut_vec(), 9'b0_01_10_00_00);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (hif.Stall_cnt !== exp_stall_cnt()) begin
            errors++; $display("FAIL stall_cnt got %0d want %0d", hif.Stall_cnt, exp_stall_cnt());
        end
        tick();
    endtask

    task automatic test_branch_jump();
        apply(1, 5, 5, 0, 0, 0, 1, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_10_10_00_00) begin
            errors++; $display("FAIL br_over_lu got %b want %b", dut_vec(), 9'b1_10_10_00_00);
        end
        tick();
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_10_00_00_00) begin
            errors++; $display("FAIL jump got %b want %b", dut_vec(), 9'b1_10_00_00_00);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (hif.Flush_cnt !== exp_flush_cnt()) begin
            errors++; $display("FAIL flush_cnt got %0d want %0d", hif.Flush_cnt, exp_flush_cnt());
        end
        checks++;
        if (hif.Stall_cnt !== exp_stall_cnt()) begin
            errors++; $display("FAIL stall_cnt_br got %0d want %0d", hif.Stall_cnt, exp_stall_cnt());
        end
        tick();
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, i == 1, 1, 0);
            checks++;
            if (dut_vec() !== 9'b0_01_01_01_10) begin
                errors++; $display("FAIL mem_stall%0d got %b want %b", i, dut_vec(), 9'b0_01_01_01_10);
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL mem_ready got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
        checks++;
        if (hif.Mem_timeout !== 1'b0) begin
            errors++; $display("FAIL mem_no_timeout got %b want 0", hif.Mem_timeout);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
            checks++;
            if (hif.Mem_timeout !== (i >= TO - 1)) begin
                errors++; $display("FAIL timeout_c%0d got %b want %b", i, hif.Mem_timeout, i >= TO - 1);
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        checks++;
        if (hif.Mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %b want 1", hif.Mem_timeout);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (hif.Mem_timeout !== 1'b0 || dut_vec() !== 9'b0_10_10_10_10) begin
            errors++; $display("FAIL reset_midwait got %b/%b want 0/%b", hif.Mem_timeout, dut_vec(), 9'b0_10_10_10_10);
        end
        @(negedge clk);
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 9'b1_00_00_00_00) begin
            errors++; $display("FAIL after_reset got %b want %b", dut_vec(), 9'b1_00_00_00_00);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            apply($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", n, dut_vec(), exp_vec());
            end
            tick();
            checks++;
            if (hif.Mem_timeout !== m_timeout || hif.Stall_cnt !== exp_stall_cnt() ||
                hif.Flush_cnt !== exp_flush_cnt()) begin
                errors++;
                $display("FAIL rand_state[%0d] got %b/%0d/%0d want %b/%0d/%0d", n, hif.Mem_timeout,
                         hif.Stall_cnt, hif.Flush_cnt, m_timeout, exp_stall_cnt(), exp_flush_cnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_uses_rt();
        test_branch_jump();
        test_mem_stall();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
